ni_histogram: RTL

NI_HISTOGRAM -- requirements
Module: ni_histogram

---
 rtl/ni_pkg.sv | 21 ++
 rtl/riu2_map.sv | 27 ++
 rtl/ni_histogram.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ni_pkg.sv
// Shared definitions for the NI histogram block: FSM states, bin count and
// bin-index width.
package ni_pkg;

    localparam int NI_WIDTH  = 8;
    localparam int NBIN      = NI_WIDTH + 2;
    localparam int BIN_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DUMP
    } state_e;

    // Number of riu2 bins for a given code width: popcounts 0..w plus one non-uniform bin.
    function automatic int nbin_of(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/riu2_map.sv
// Combinational rotation-invariant uniform (riu2) mapping of an NI code to
// its histogram bin.
module riu2_map
    import ni_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     i_code,
    output logic [BIN_IDX_W-1:0] o_bin
);

    logic [BIN_IDX_W-1:0] ones;
    logic [BIN_IDX_W-1:0] trans;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        ones  = '0;
        trans = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ones  = ones + BIN_IDX_W'(i_code[k]);
            // The last point wraps around to point 0, closing the circle.
            trans = trans + BIN_IDX_W'(i_code[k] ^ i_code[(k == WIDTH - 1) ? 0 : k + 1]);
        end
        o_bin = (trans <= BIN_IDX_W'(2)) ? ones : BIN_IDX_W'(WIDTH + 1);
    end

endmodule

// File: rtl/ni_histogram.sv
// Per-frame riu2 histogram of NI codes: two-stage accumulate pipeline, then a
// clear-on-read dump of all bins over a valid/ready handshake.
module ni_histogram
    import ni_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_code,
    input  logic                 i_sof,
    input  logic                 i_eof,
    output logic                 o_ready,
    output logic                 o_bin_valid,
    output logic [3:0]           o_bin_idx,
    output logic [CNT_W-1:0]     o_bin_cnt,
    input  logic                 i_bin_ready,
    output logic                 o_frame_done
);

    localparam int                   NB       = nbin_of(WIDTH);
    localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(NB - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic                 drain_q, drain_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [BIN_IDX_W-1:0] s1_bin_q, s1_bin_d;
    logic [CNT_W-1:0]     cnt_q [NB];
    logic [CNT_W-1:0]     cnt_d [NB];
    logic                 bin_valid_q, bin_valid_d;
    logic [BIN_IDX_W-1:0] bin_idx_q, bin_idx_d;
    logic [CNT_W-1:0]     bin_cnt_q, bin_cnt_d;

    logic [BIN_IDX_W-1:0] code_bin;
    logic                 accept;
    logic                 count_code;
    logic                 restart;

    riu2_map #(.WIDTH(WIDTH)) u_riu2_map (
        .i_code (i_code),
        .o_bin  (code_bin)
    );

    assign o_ready      = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign accept       = i_valid && o_ready;
    // Outside a frame only a start-of-frame code is counted; everything else is dropped.
    assign count_code   = accept && ((state_q == ST_ACCUM) || i_sof);
    assign restart      = count_code && i_sof;

    assign o_bin_valid  = bin_valid_q;
    assign o_bin_idx    = bin_idx_q;
    assign o_bin_cnt    = bin_cnt_q;
    assign o_frame_done = bin_valid_q && i_bin_ready && (bin_idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cnt_d       = cnt_q;
        bin_valid_d = bin_valid_q;
        bin_idx_d   = bin_idx_q;
        bin_cnt_d   = bin_cnt_q;

        s1_valid_d  = count_code;
        s1_bin_d    = code_bin;

        // A new frame start wipes the counters and drops the increment still in stage 2.
        if (restart) begin
            cnt_d = '{default: '0};
        end else if (s1_valid_q && (cnt_q[s1_bin_q] != CNT_MAX)) begin
            cnt_d[s1_bin_q] = cnt_q[s1_bin_q] + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (count_code) begin
                    state_d = i_eof ? ST_DRAIN : ST_ACCUM;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d     = ST_DUMP;
                    bin_valid_d = 1'b1;
                    bin_idx_d   = '0;
                    bin_cnt_d   = cnt_q[0];
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DUMP: begin
                if (i_bin_ready) begin
                    cnt_d[bin_idx_q] = '0;
                    if (bin_idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        bin_valid_d = 1'b0;
                        bin_idx_d   = '0;
                        bin_cnt_d   = '0;
                    end else begin
                        bin_idx_d = bin_idx_q + BIN_IDX_W'(1);
                        bin_cnt_d = cnt_q[bin_idx_q + BIN_IDX_W'(1)];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            bin_valid_q <= 1'b0;
            bin_idx_q   <= '0;
            bin_cnt_q   <= '0;
            // NOTE: the counter array is reset because its contents are architectural: a reset must discard any partial frame.
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            s1_valid_q  <= s1_valid_d;
            s1_bin_q    <= s1_bin_d;
            bin_valid_q <= bin_valid_d;
            bin_idx_q   <= bin_idx_d;
            bin_cnt_q   <= bin_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
